dispatch_queue: RTL and testbench

Buffered, parametrised dispatch stage between the decoder and the three reservation stations (ALU, Branch, Load/Store). It accepts one decoded instruction per cycle into an in-order queue of `DEPTH` entries and resolves each source operand from regfile, ROB or a same-cycle CDB broadcast. Queued entries keep snooping `N_CDB` broadcast buses until their operands are ready. The head entry is issued to its target RS only when that RS is not full, so decode is decoupled from RS back-pressure and flushes are supported.

---
 rtl/dispatch_queue.sv | 222 ++++++++++++++++++++++
 tb/tb_dispatch_queue.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order dispatch queue feeding the ALU, Branch and LSB reservation stations
module dispatch_queue #(
   parameter int DEPTH  = 4,
   parameter int N_CDB  = 2,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4,
   parameter int OP_W   = 6
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    rdy_in,
   input  logic                    flush_in,
   input  logic                    ID_valid,
   output logic                    ID_ready,
   input  logic [1:0]              ID_class,
   input  logic [OP_W-1:0]         ID_op,
   input  logic [DATA_W-1:0]       ID_imm,
   input  logic [DATA_W-1:0]       ID_pc,
   input  logic [TAG_W-1:0]        ID_reg_dest_tag,
   input  logic                    regfile_reg1_valid,
   input  logic [DATA_W-1:0]       regfile_reg1_data,
   input  logic [TAG_W-1:0]        regfile_reg1_tag,
   input  logic                    regfile_reg2_valid,
   input  logic [DATA_W-1:0]       regfile_reg2_data,
   input  logic [TAG_W-1:0]        regfile_reg2_tag,
   output logic [TAG_W-1:0]        ROB_reg1_tag,
   output logic [TAG_W-1:0]        ROB_reg2_tag,
   input  logic                    ROB_reg1_valid,
   input  logic [DATA_W-1:0]       ROB_reg1_data,
   input  logic                    ROB_reg2_valid,
   input  logic [DATA_W-1:0]       ROB_reg2_data,
   input  logic [N_CDB-1:0]        CDB_valid,
   input  logic [N_CDB*TAG_W-1:0]  CDB_tag,
   input  logic [N_CDB*DATA_W-1:0] CDB_data,
   input  logic                    ALURS_full,
   input  logic                    BranchRS_full,
   input  logic                    LSBRS_full,
   output logic                    ALURS_enable,
   output logic                    BranchRS_enable,
   output logic                    LSBRS_enable,
   output logic [OP_W-1:0]         RS_op,
   output logic [DATA_W-1:0]       RS_imm,
   output logic [DATA_W-1:0]       RS_pc,
   output logic [TAG_W-1:0]        RS_reg_dest_tag,
   output logic                    RS_reg1_valid,
   output logic [DATA_W-1:0]       RS_reg1_data,
   output logic [TAG_W-1:0]        RS_reg1_tag,
   output logic                    RS_reg2_valid,
   output logic [DATA_W-1:0]       RS_reg2_data,
   output logic [TAG_W-1:0]        RS_reg2_tag
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
   localparam logic [1:0]       CLS_ALU  = 2'd0;
   localparam logic [1:0]       CLS_BR   = 2'd1;
   localparam logic [1:0]       CLS_LSB  = 2'd2;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } opnd_t;

   logic              q_valid [DEPTH];
   logic [1:0]        q_cls   [DEPTH];
   logic [OP_W-1:0]   q_op    [DEPTH];
   logic [DATA_W-1:0] q_imm   [DEPTH];
   logic [DATA_W-1:0] q_pc    [DEPTH];
   logic [TAG_W-1:0]  q_dest  [DEPTH];
   opnd_t             q_s1    [DEPTH];
   opnd_t             q_s2    [DEPTH];
   opnd_t             w_s1    [DEPTH];
   opnd_t             w_s2    [DEPTH];
   opnd_t             new_s1, new_s2;

   logic [PTR_W-1:0]  head, tail;
   logic [PTR_W:0]    count;
   logic              head_full, do_disp, do_enq;

   // A pending operand picks up the first (lowest-index) CDB bus carrying its tag; Null never matches.
   function automatic opnd_t snoop(input opnd_t o);
      opnd_t r;
      r = o;
      if (!o.valid && o.tag != '0) begin
         for (int i = N_CDB-1; i >= 0; i--) begin
            if (CDB_valid[i] && CDB_tag[i*TAG_W +: TAG_W] == o.tag) begin
               r.valid = 1'b1;
               r.data  = CDB_data[i*DATA_W +: DATA_W];
               r.tag   = '0;
            end
         end
      end
      return r;
   endfunction

   // Enqueue-time resolution order: regfile, then ROB, then a same-cycle broadcast.
   function automatic opnd_t capture(input logic rf_v, input logic [DATA_W-1:0] rf_d,
                                     input logic [TAG_W-1:0] rf_t, input logic rob_v,
                                     input logic [DATA_W-1:0] rob_d);
      opnd_t r;
      if (rf_v)       r = '{valid: 1'b1, data: rf_d, tag: '0};
      else if (rob_v) r = '{valid: 1'b1, data: rob_d, tag: '0};
      else            r = snoop('{valid: 1'b0, data: '0, tag: rf_t});
      return r;
   endfunction

   assign ROB_reg1_tag = regfile_reg1_tag;
   assign ROB_reg2_tag = regfile_reg2_tag;
   assign ID_ready     = rst_n_in && (count != FULL_CNT) && rdy_in && !flush_in;
   assign do_enq       = ID_valid && ID_ready;

   // Post-wakeup view of every entry plus the operands of the incoming instruction.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_s1[i] = snoop(q_s1[i]);
         w_s2[i] = snoop(q_s2[i]);
      end
      new_s1 = capture(regfile_reg1_valid, regfile_reg1_data, regfile_reg1_tag,
                       ROB_reg1_valid, ROB_reg1_data);
      new_s2 = capture(regfile_reg2_valid, regfile_reg2_data, regfile_reg2_tag,
                       ROB_reg2_valid, ROB_reg2_data);
   end

   // The head may leave only when its own reservation station has room.
   always_comb begin
      head_full = ALURS_full;
      case (q_cls[head])
         CLS_BR:  head_full = BranchRS_full;
         CLS_LSB: head_full = LSBRS_full;
         default: head_full = ALURS_full;
      endcase
      do_disp = rdy_in && !flush_in && (count != '0) && !head_full;
   end

   // Queue state, wakeup, dispatch payload and strobes.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         ALURS_enable    <= 1'b0;
         BranchRS_enable <= 1'b0;
         LSBRS_enable    <= 1'b0;
         RS_op           <= '0;
         RS_imm          <= '0;
         RS_pc           <= '0;
         RS_reg_dest_tag <= '0;
         RS_reg1_valid   <= 1'b0;
         RS_reg1_data    <= '0;
         RS_reg1_tag     <= '0;
         RS_reg2_valid   <= 1'b0;
         RS_reg2_data    <= '0;
         RS_reg2_tag     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_valid[i] <= 1'b0;
            q_cls[i]   <= '0;
            q_op[i]    <= '0;
            q_imm[i]   <= '0;
            q_pc[i]    <= '0;
            q_dest[i]  <= '0;
            q_s1[i]    <= '0;
            q_s2[i]    <= '0;
         end
      end else if (!rdy_in) begin
         ALURS_enable    <= 1'b0;
         BranchRS_enable <= 1'b0;
         LSBRS_enable    <= 1'b0;
      end else begin
         ALURS_enable    <= 1'b0;
         BranchRS_enable <= 1'b0;
         LSBRS_enable    <= 1'b0;
         if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q_valid[i] <= 1'b0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (q_valid[i]) begin
                  q_s1[i] <= w_s1[i];
                  q_s2[i] <= w_s2[i];
               end
            end
            if (do_disp) begin
               ALURS_enable    <= (q_cls[head] == CLS_ALU);
               BranchRS_enable <= (q_cls[head] == CLS_BR);
               LSBRS_enable    <= (q_cls[head] == CLS_LSB);
               RS_op           <= q_op[head];
               RS_imm          <= q_imm[head];
               RS_pc           <= q_pc[head];
               RS_reg_dest_tag <= q_dest[head];
               RS_reg1_valid   <= w_s1[head].valid;
               RS_reg1_data    <= w_s1[head].data;
               RS_reg1_tag     <= w_s1[head].tag;
               RS_reg2_valid   <= w_s2[head].valid;
               RS_reg2_data    <= w_s2[head].data;
               RS_reg2_tag     <= w_s2[head].tag;
               q_valid[head]   <= 1'b0;
               head            <= head + ONE_PTR;
            end
            if (do_enq) begin
               q_valid[tail] <= 1'b1;
               q_cls[tail]   <= (ID_class == 2'd3) ? CLS_ALU : ID_class;
               q_op[tail]    <= ID_op;
               q_imm[tail]   <= ID_imm;
               q_pc[tail]    <= ID_pc;
               q_dest[tail]  <= ID_reg_dest_tag;
               q_s1[tail]    <= new_s1;
               q_s2[tail]    <= new_s2;
               tail          <= tail + ONE_PTR;
            end
            case ({do_enq, do_disp})
               2'b10:   count <= count + ONE_CNT;
               2'b01:   count <= count - ONE_CNT;
               default: count <= count;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - self-checking bench for dispatch_queue
module tb_dispatch_queue;
   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        rdy_in = 1'b1, flush_in = 1'b0;
   logic        ID_valid, ID_ready;
   logic [1:0]  ID_class;
   logic [5:0]  ID_op;
   logic [31:0] ID_imm, ID_pc;
   logic [3:0]  ID_reg_dest_tag;
   logic        regfile_reg1_valid, regfile_reg2_valid;
   logic [31:0] regfile_reg1_data, regfile_reg2_data;
   logic [3:0]  regfile_reg1_tag, regfile_reg2_tag;
   logic [3:0]  ROB_reg1_tag, ROB_reg2_tag;
   logic        ROB_reg1_valid, ROB_reg2_valid;
   logic [31:0] ROB_reg1_data, ROB_reg2_data;
   logic [1:0]  CDB_valid;
   logic [7:0]  CDB_tag;
   logic [63:0] CDB_data;
   logic        ALURS_full = 1'b0, BranchRS_full = 1'b0, LSBRS_full = 1'b0;
   logic        ALURS_enable, BranchRS_enable, LSBRS_enable;
   logic [5:0]  RS_op;
   logic [31:0] RS_imm, RS_pc;
   logic [3:0]  RS_reg_dest_tag;
   logic        RS_reg1_valid, RS_reg2_valid;
   logic [31:0] RS_reg1_data, RS_reg2_data;
   logic [3:0]  RS_reg1_tag, RS_reg2_tag;

   int n_cmp = 0;
   int n_bad = 0;

   dispatch_queue #(.DEPTH(4), .N_CDB(2), .DATA_W(32), .TAG_W(4), .OP_W(6)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .ID_valid(ID_valid), .ID_ready(ID_ready), .ID_class(ID_class), .ID_op(ID_op),
      .ID_imm(ID_imm), .ID_pc(ID_pc), .ID_reg_dest_tag(ID_reg_dest_tag),
      .regfile_reg1_valid(regfile_reg1_valid), .regfile_reg1_data(regfile_reg1_data),
      .regfile_reg1_tag(regfile_reg1_tag), .regfile_reg2_valid(regfile_reg2_valid),
      .regfile_reg2_data(regfile_reg2_data), .regfile_reg2_tag(regfile_reg2_tag),
      .ROB_reg1_tag(ROB_reg1_tag), .ROB_reg2_tag(ROB_reg2_tag),
      .ROB_reg1_valid(ROB_reg1_valid), .ROB_reg1_data(ROB_reg1_data),
      .ROB_reg2_valid(ROB_reg2_valid), .ROB_reg2_data(ROB_reg2_data),
      .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
      .ALURS_full(ALURS_full), .BranchRS_full(BranchRS_full), .LSBRS_full(LSBRS_full),
      .ALURS_enable(ALURS_enable), .BranchRS_enable(BranchRS_enable), .LSBRS_enable(LSBRS_enable),
      .RS_op(RS_op), .RS_imm(RS_imm), .RS_pc(RS_pc), .RS_reg_dest_tag(RS_reg_dest_tag),
      .RS_reg1_valid(RS_reg1_valid), .RS_reg1_data(RS_reg1_data), .RS_reg1_tag(RS_reg1_tag),
      .RS_reg2_valid(RS_reg2_valid), .RS_reg2_data(RS_reg2_data), .RS_reg2_tag(RS_reg2_tag)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { logic v; logic [31:0] d; logic [3:0] t; } mop_t;
   typedef struct { logic [1:0] cls; logic [5:0] op; logic [31:0] imm, pc; logic [3:0] dest; mop_t s1, s2; } ment_t;

   ment_t mq[$];
   ment_t m_pay;
   logic  m_alu = 1'b0, m_br = 1'b0, m_lsb = 1'b0;

   function automatic ment_t zero_ent();
      ment_t e;
      e.cls = 2'd0; e.op = 6'd0; e.imm = 32'd0; e.pc = 32'd0; e.dest = 4'd0;
      e.s1 = '{1'b0, 32'h0, 4'h0};
      e.s2 = e.s1;
      return e;
   endfunction

   function automatic mop_t from_cdb(input mop_t o);
      if (o.v || o.t == 4'd0) return o;
      for (int i = 0; i < 2; i++)
         if (CDB_valid[i] && CDB_tag[i*4 +: 4] == o.t) return '{1'b1, CDB_data[i*32 +: 32], 4'd0};
      return o;
   endfunction

   function automatic mop_t resolve(input logic rv, input logic [31:0] rd, input logic [3:0] rt,
                                    input logic bv, input logic [31:0] bd);
      if (rv) return '{1'b1, rd, 4'd0};
      if (bv) return '{1'b1, bd, 4'd0};
      return from_cdb('{1'b0, 32'h0, rt});
   endfunction

   function automatic logic rs_full(input logic [1:0] c);
      return (c == 2'd1) ? BranchRS_full : (c == 2'd2) ? LSBRS_full : ALURS_full;
   endfunction

   initial m_pay = zero_ent();

   always @(posedge clk_in or negedge rst_n_in) begin
      ment_t e;
      bit    acc;
      if (!rst_n_in) begin
         mq.delete();
         m_pay = zero_ent();
         m_alu = 1'b0; m_br = 1'b0; m_lsb = 1'b0;
      end else begin
         m_alu = 1'b0; m_br = 1'b0; m_lsb = 1'b0;
         if (rdy_in) begin
            if (flush_in) mq.delete();
            else begin
               acc = ID_valid && (mq.size() != 4);
               foreach (mq[i]) begin
                  mq[i].s1 = from_cdb(mq[i].s1);
                  mq[i].s2 = from_cdb(mq[i].s2);
               end
               if (mq.size() > 0 && !rs_full(mq[0].cls)) begin
                  m_pay = mq.pop_front();
                  m_alu = (m_pay.cls == 2'd0);
                  m_br  = (m_pay.cls == 2'd1);
                  m_lsb = (m_pay.cls == 2'd2);
               end
               if (acc) begin
                  e.cls  = (ID_class == 2'd3) ? 2'd0 : ID_class;
                  e.op   = ID_op; e.imm = ID_imm; e.pc = ID_pc; e.dest = ID_reg_dest_tag;
                  e.s1   = resolve(regfile_reg1_valid, regfile_reg1_data, regfile_reg1_tag, ROB_reg1_valid, ROB_reg1_data);
                  e.s2   = resolve(regfile_reg2_valid, regfile_reg2_data, regfile_reg2_tag, ROB_reg2_valid, ROB_reg2_data);
                  mq.push_back(e);
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk_in) begin
      chk("ID_ready", ID_ready, rst_n_in && (mq.size() != 4) && rdy_in && !flush_in);
      chk("ROB_reg1_tag", ROB_reg1_tag, regfile_reg1_tag);
      chk("ROB_reg2_tag", ROB_reg2_tag, regfile_reg2_tag);
      chk("ALURS_enable", ALURS_enable, m_alu);
      chk("BranchRS_enable", BranchRS_enable, m_br);
      chk("LSBRS_enable", LSBRS_enable, m_lsb);
      chk("RS_op", RS_op, m_pay.op);
      chk("RS_imm", RS_imm, m_pay.imm);
      chk("RS_pc", RS_pc, m_pay.pc);
      chk("RS_reg_dest_tag", RS_reg_dest_tag, m_pay.dest);
      chk("RS_reg1_valid", RS_reg1_valid, m_pay.s1.v);
      chk("RS_reg1_data", RS_reg1_data, m_pay.s1.d);
      chk("RS_reg1_tag", RS_reg1_tag, m_pay.s1.t);
      chk("RS_reg2_valid", RS_reg2_valid, m_pay.s2.v);
      chk("RS_reg2_data", RS_reg2_data, m_pay.s2.d);
      chk("RS_reg2_tag", RS_reg2_tag, m_pay.s2.t);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      ID_valid = 1'b0; ID_class = 2'd0; ID_op = 6'd0; ID_imm = 32'd0; ID_pc = 32'd0; ID_reg_dest_tag = 4'd0;
      regfile_reg1_valid = 1'b0; regfile_reg1_data = 32'd0; regfile_reg1_tag = 4'd0;
      regfile_reg2_valid = 1'b0; regfile_reg2_data = 32'd0; regfile_reg2_tag = 4'd0;
      ROB_reg1_valid = 1'b0; ROB_reg1_data = 32'd0; ROB_reg2_valid = 1'b0; ROB_reg2_data = 32'd0;
      CDB_valid = 2'b00; CDB_tag = 8'd0; CDB_data = 64'd0;
   endtask

   task automatic put_op(input logic [1:0] cls, input logic [5:0] op,
                         input logic r1v, input logic [31:0] r1d, input logic [3:0] r1t,
                         input logic r2v, input logic [31:0] r2d, input logic [3:0] r2t);
      idle_inputs();
      ID_valid = 1'b1; ID_class = cls; ID_op = op;
      ID_imm = {26'h0, op} ^ 32'hA5A5_0000;
      ID_pc = 32'h1000 + {24'h0, op, 2'b00};
      ID_reg_dest_tag = op[3:0];
      regfile_reg1_valid = r1v; regfile_reg1_data = r1d; regfile_reg1_tag = r1t;
      regfile_reg2_valid = r2v; regfile_reg2_data = r2d; regfile_reg2_tag = r2t;
   endtask

   task automatic cdb(input int bus, input logic [3:0] tag, input logic [31:0] data);
      CDB_valid[bus] = 1'b1;
      CDB_tag[bus*4 +: 4] = tag;
      CDB_data[bus*32 +: 32] = data;
   endtask

   initial begin
      idle_inputs();
      repeat (2) tick();
      chk("reset_ID_ready", ID_ready, 1'b0);
      chk("reset_alu_en", ALURS_enable, 1'b0);
      chk("reset_reg1_valid", RS_reg1_valid, 1'b0);
      rst_n_in = 1'b1;
      tick();

      // basic accept and dispatch
      put_op(2'd0, 6'h01, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0);
      tick();
      idle_inputs();
      tick();
      chk("t1_alu_en", ALURS_enable, 1'b1);
      chk("t1_reg1_data", RS_reg1_data, 32'h11);
      chk("t1_reg2_data", RS_reg2_data, 32'h22);
      chk("t1_reg1_tag", RS_reg1_tag, 4'd0);
      chk("t1_reg2_tag", RS_reg2_tag, 4'd0);

      // back-pressure: 5 offered, 4 accepted
      LSBRS_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         put_op(2'd2, 6'(6'h10 + k), 1'b1, 32'h100 + k, 4'd0, 1'b1, 32'h200 + k, 4'd0);
         tick();
      end
      idle_inputs();
      #1;
      chk("bp_ID_ready", ID_ready, 1'b0);
      chk("bp_lsb_en", LSBRS_enable, 1'b0);
      LSBRS_full = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp_drain_en", LSBRS_enable, 1'b1);
         chk("bp_drain_op", RS_op, 6'(6'h10 + k));
         chk("bp_drain_d1", RS_reg1_data, 32'h100 + k);
      end
      tick();
      chk("bp_empty_en", LSBRS_enable, 1'b0);

      // wakeup while queued
      ALURS_full = 1'b1;
      put_op(2'd0, 6'h03, 1'b0, 32'h0, 4'd3, 1'b1, 32'h44, 4'd0);
      tick();
      idle_inputs();
      cdb(1, 4'd3, 32'hABCD);
      tick();
      idle_inputs();
      ALURS_full = 1'b0;
      tick();
      chk("wk_alu_en", ALURS_enable, 1'b1);
      chk("wk_v1", RS_reg1_valid, 1'b1);
      chk("wk_d1", RS_reg1_data, 32'hABCD);
      chk("wk_t1", RS_reg1_tag, 4'd0);

      // same-cycle CDB at enqueue, both buses match: bus 0 wins
      put_op(2'd0, 6'h05, 1'b0, 32'h0, 4'd5, 1'b1, 32'h55, 4'd0);
      cdb(0, 4'd5, 32'h5555);
      cdb(1, 4'd5, 32'h6666);
      tick();
      idle_inputs();
      tick();
      chk("fwd_enq_v1", RS_reg1_valid, 1'b1);
      chk("fwd_enq_d1", RS_reg1_data, 32'h5555);

      // same-cycle CDB at the dispatch edge
      put_op(2'd0, 6'h06, 1'b0, 32'h0, 4'd5, 1'b1, 32'h66, 4'd0);
      tick();
      idle_inputs();
      cdb(1, 4'd5, 32'h7777);
      tick();
      idle_inputs();
      chk("fwd_disp_v1", RS_reg1_valid, 1'b1);
      chk("fwd_disp_d1", RS_reg1_data, 32'h7777);
      chk("fwd_disp_t1", RS_reg1_tag, 4'd0);

      // no match dispatches unresolved; reg2 comes from the ROB
      put_op(2'd0, 6'h07, 1'b0, 32'h0, 4'd5, 1'b0, 32'h0, 4'd9);
      ROB_reg2_valid = 1'b1;
      ROB_reg2_data = 32'h3333;
      tick();
      idle_inputs();
      tick();
      chk("nm_v1", RS_reg1_valid, 1'b0);
      chk("nm_t1", RS_reg1_tag, 4'd5);
      chk("rob_v2", RS_reg2_valid, 1'b1);
      chk("rob_d2", RS_reg2_data, 32'h3333);

      // flush with 3 queued and a concurrent enqueue attempt
      ALURS_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         put_op(2'd0, 6'(6'h20 + k), 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
         tick();
      end
      put_op(2'd1, 6'h2F, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
      flush_in = 1'b1;
      tick();
      chk("fl_alu_en", ALURS_enable, 1'b0);
      chk("fl_br_en", BranchRS_enable, 1'b0);
      flush_in = 1'b0;
      ALURS_full = 1'b0;
      idle_inputs();
      #1;
      chk("fl_ready_after", ID_ready, 1'b1);
      tick();
      chk("fl_empty_en", ALURS_enable, 1'b0);
      chk("fl_empty_br", BranchRS_enable, 1'b0);
      put_op(2'd0, 6'h2A, 1'b1, 32'h9, 4'd0, 1'b1, 32'hA, 4'd0);
      tick();
      idle_inputs();
      tick();
      chk("fl_next_en", ALURS_enable, 1'b1);
      chk("fl_next_op", RS_op, 6'h2A);

      // 10-op mixed stream with wraparound
      for (int k = 0; k < 10; k++) begin
         put_op(2'(k % 4), 6'(6'h30 + k), 1'b1, 32'h300 + k, 4'd0, 1'b1, 32'h400 + k, 4'd0);
         tick();
         if (k > 0) begin
            chk("st_alu", ALURS_enable, ((k-1) % 4 == 0) || ((k-1) % 4 == 3));
            chk("st_br", BranchRS_enable, (k-1) % 4 == 1);
            chk("st_lsb", LSBRS_enable, (k-1) % 4 == 2);
            chk("st_op", RS_op, 6'(6'h30 + k - 1));
         end
      end
      idle_inputs();
      tick();
      chk("st_last_br", BranchRS_enable, 1'b1);
      chk("st_last_op", RS_op, 6'h39);

      // rdy_in stall freezes dispatch
      put_op(2'd0, 6'h3A, 1'b1, 32'h5, 4'd0, 1'b1, 32'h6, 4'd0);
      tick();
      idle_inputs();
      rdy_in = 1'b0;
      tick();
      chk("stall_en0", ALURS_enable, 1'b0);
      tick();
      chk("stall_en1", ALURS_enable, 1'b0);
      chk("stall_hold_op", RS_op, 6'h39);
      rdy_in = 1'b1;
      tick();
      chk("stall_rel_en", ALURS_enable, 1'b1);
      chk("stall_rel_op", RS_op, 6'h3A);

      // mid-operation reset discards queued entries
      ALURS_full = 1'b1;
      for (int k = 0; k < 2; k++) begin
         put_op(2'd0, 6'(6'h3C + k), 1'b1, 32'h7, 4'd0, 1'b1, 32'h8, 4'd0);
         tick();
      end
      idle_inputs();
      rst_n_in = 1'b0;
      #1;
      chk("mr_op_cleared", RS_op, 6'h0);
      tick();
      rst_n_in = 1'b1;
      ALURS_full = 1'b0;
      tick();
      chk("mr_no_disp0", ALURS_enable, 1'b0);
      tick();
      chk("mr_no_disp1", ALURS_enable, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
